// File: rtl/puc_cpu_pkg.sv
// puc_cpu shared definitions: opcodes, instruction fields, ROM image helpers.
// The default ROM image holds the switch-driven up/down counter program.
package puc_cpu_pkg;

  localparam int INSTR_W   = 16;
  localparam int OPC_LSB   = 12;
  localparam int RD_LSB    = 10;
  localparam int RS_LSB    = 8;
  localparam int IMM_LSB   = 0;
  localparam int OPC_W     = 4;
  localparam int REG_SEL_W = 2;
  localparam int IMM_W     = 8;
  localparam int ROM_WORDS = 256;
  localparam int ROM_BITS  = ROM_WORDS * INSTR_W;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDI  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_ADDI = 4'd4,
    OP_MOV  = 4'd5,
    OP_JMP  = 4'd6,
    OP_BSW  = 4'd7,
    OP_BNZ  = 4'd8,
    OP_HALT = 4'd9
  } opcode_t;

  function automatic logic [INSTR_W-1:0] enc(
    input logic [3:0] op,
    input logic [1:0] rd,
    input logic [1:0] rs,
    input logic [7:0] imm
  );
    return {op, rd, rs, imm};
  endfunction

  // Word 0 sits in the least significant 16 bits of the image.
  function automatic logic [ROM_BITS-1:0] default_rom();
    return ROM_BITS'({
      enc(OP_JMP,  2'd0, 2'd0, 8'h01),
      enc(OP_ADDI, 2'd1, 2'd0, 8'h01),
      enc(OP_JMP,  2'd0, 2'd0, 8'h01),
      enc(OP_ADDI, 2'd1, 2'd0, 8'hFF),
      enc(OP_BSW,  2'd0, 2'd0, 8'h04),
      enc(OP_LDI,  2'd1, 2'd0, 8'h00)
    });
  endfunction

endpackage

// File: rtl/puc_cpu_regfile.sv
// puc_cpu register file: four entries, one write port,
// two combinational read ports and a direct tap of r1.
module puc_cpu_regfile #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_we,
  input  logic [1:0]   i_waddr,
  input  logic [W-1:0] i_wdata,
  input  logic [1:0]   i_raddr_a,
  input  logic [1:0]   i_raddr_b,
  output logic [W-1:0] o_rdata_a,
  output logic [W-1:0] o_rdata_b,
  output logic [W-1:0] o_r1
);

  logic [W-1:0] r_regs [4];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];
  assign o_r1      = r_regs[1];

endmodule

// File: rtl/puc_cpu.sv
// puc_cpu: single-cycle 16-bit-instruction CPU with internal ROM.
// Optional macro PUC_CPU_SWITCH_SYNC_EN adds a 2-flop switch synchroniser.
module puc_cpu
  import puc_cpu_pkg::*;
#(
  parameter int PC_WIDTH       = 8,
  parameter int REGISTER_WIDTH = 8,
  parameter logic [ROM_BITS-1:0] ROM_IMAGE = default_rom()
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic                      switch,
  output logic [PC_WIDTH-1:0]       pc,
  output logic [REGISTER_WIDTH-1:0] register1Value
);

  localparam int RomIdxW = $clog2(ROM_BITS);

  logic [PC_WIDTH-1:0]       r_pc;
  logic [PC_WIDTH-1:0]       w_pc_next;
  logic [PC_WIDTH-1:0]       w_pc_inc;
  logic [PC_WIDTH-1:0]       w_tgt;
  logic [RomIdxW-1:0]        w_rom_idx;
  logic [INSTR_W-1:0]        w_instr;
  logic [OPC_W-1:0]          w_op;
  logic [REG_SEL_W-1:0]      w_rd;
  logic [REG_SEL_W-1:0]      w_rs;
  logic [IMM_W-1:0]          w_imm;
  logic [REGISTER_WIDTH-1:0] w_imm_ext;
  logic [REGISTER_WIDTH-1:0] w_rd_val;
  logic [REGISTER_WIDTH-1:0] w_rs_val;
  logic [REGISTER_WIDTH-1:0] w_wdata;
  logic                      w_we;
  logic                      w_switch;

`ifdef PUC_CPU_SWITCH_SYNC_EN
  logic r_sw_meta;
  logic r_sw_sync;

  always_ff @(posedge clock) begin
    if (isReset) begin
      r_sw_meta <= 1'b0;
      r_sw_sync <= 1'b0;
    end else begin
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign w_switch = r_sw_sync;
`else
  assign w_switch = switch;
`endif

  // Each ROM word is 16 bits; pc selects the word.
  assign w_rom_idx = RomIdxW'({r_pc, 4'b0000});
  assign w_instr   = ROM_IMAGE[w_rom_idx +: INSTR_W];

  assign w_op      = w_instr[OPC_LSB +: OPC_W];
  assign w_rd      = w_instr[RD_LSB +: REG_SEL_W];
  assign w_rs      = w_instr[RS_LSB +: REG_SEL_W];
  assign w_imm     = w_instr[IMM_LSB +: IMM_W];
  assign w_imm_ext = REGISTER_WIDTH'(w_imm);
  assign w_tgt     = PC_WIDTH'(w_imm);
  assign w_pc_inc  = r_pc + PC_WIDTH'(1);

  puc_cpu_regfile #(
    .W(REGISTER_WIDTH)
  ) u_regfile (
    .i_clk     (clock),
    .i_rst     (isReset),
    .i_we      (w_we),
    .i_waddr   (w_rd),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_rd),
    .i_raddr_b (w_rs),
    .o_rdata_a (w_rd_val),
    .o_rdata_b (w_rs_val),
    .o_r1      (register1Value)
  );

  always_comb begin
    w_we      = 1'b0;
    w_wdata   = '0;
    w_pc_next = w_pc_inc;
    case (w_op)
      OP_LDI: begin
        w_we    = 1'b1;
        w_wdata = w_imm_ext;
      end
      OP_ADD: begin
        w_we    = 1'b1;
        w_wdata = w_rd_val + w_rs_val;
      end
      OP_SUB: begin
        w_we    = 1'b1;
        w_wdata = w_rd_val - w_rs_val;
      end
      OP_ADDI: begin
        w_we    = 1'b1;
        w_wdata = w_rd_val + w_imm_ext;
      end
      OP_MOV: begin
        w_we    = 1'b1;
        w_wdata = w_rs_val;
      end
      OP_JMP: w_pc_next = w_tgt;
      OP_BSW: if (w_switch) w_pc_next = w_tgt;
      OP_BNZ: if (w_rd_val != '0) w_pc_next = w_tgt;
      // Holding pc re-fetches HALT forever, freezing the machine.
      OP_HALT: w_pc_next = r_pc;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (isReset) r_pc <= '0;
    else         r_pc <= w_pc_next;
  end

  assign pc = r_pc;

endmodule

// File: tb/tb_puc_cpu.sv
// puc_cpu bench: default-program DUT plus three custom-ROM DUTs,
// checked through an expected-value queue drained after each edge.
module tb_puc_cpu;
  import puc_cpu_pkg::*;

`ifdef PUC_CPU_SWITCH_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  localparam logic [ROM_BITS-1:0] ROM_SUB = ROM_BITS'({
    enc(OP_HALT, 2'd0, 2'd0, 8'h00),
    enc(OP_SUB,  2'd1, 2'd2, 8'h00),
    enc(OP_LDI,  2'd1, 2'd0, 8'h03),
    enc(OP_LDI,  2'd2, 2'd0, 8'h05)
  });

  localparam logic [ROM_BITS-1:0] ROM_BNZ = ROM_BITS'({
    enc(OP_HALT, 2'd0, 2'd0, 8'h00),
    enc(OP_BNZ,  2'd1, 2'd0, 8'h01),
    enc(OP_ADDI, 2'd1, 2'd0, 8'hFF),
    enc(OP_LDI,  2'd1, 2'd0, 8'h02)
  });

  localparam logic [ROM_BITS-1:0] ROM_MISC = ROM_BITS'({
    enc(OP_NOP,  2'd0, 2'd0, 8'h00),
    enc(OP_NOP,  2'd0, 2'd0, 8'h00),
    enc(OP_ADDI, 2'd1, 2'd0, 8'hF3),
    enc(OP_JMP,  2'd0, 2'd0, 8'h0D),
    enc(4'hF,    2'd3, 2'd3, 8'hAA),
    enc(OP_ADD,  2'd1, 2'd0, 8'h00),
    enc(OP_MOV,  2'd1, 2'd0, 8'h00),
    enc(OP_LDI,  2'd0, 2'd0, 8'h07)
  });

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] r1;
    string       tag;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst_a;
  logic       rst_p;
  logic       sw;
  logic [7:0] pc_a, r1_a;
  logic [7:0] pc_s, r1_s;
  logic [7:0] pc_b, r1_b;
  logic [2:0] pc_m;
  logic [7:0] r1_m;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] m_pc, m_r1;
  logic       m_s1, m_s2;

  always #5 clock = ~clock;

  puc_cpu dut (
    .clock(clock), .isReset(rst_a), .switch(sw),
    .pc(pc_a), .register1Value(r1_a)
  );

  puc_cpu #(.ROM_IMAGE(ROM_SUB)) dut_sub (
    .clock(clock), .isReset(rst_p), .switch(sw),
    .pc(pc_s), .register1Value(r1_s)
  );

  puc_cpu #(.ROM_IMAGE(ROM_BNZ)) dut_bnz (
    .clock(clock), .isReset(rst_p), .switch(sw),
    .pc(pc_b), .register1Value(r1_b)
  );

  puc_cpu #(.PC_WIDTH(3), .ROM_IMAGE(ROM_MISC)) dut_misc (
    .clock(clock), .isReset(rst_p), .switch(sw),
    .pc(pc_m), .register1Value(r1_m)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs_pc(input int id);
    case (id)
      0:       return 32'(pc_a);
      1:       return 32'(pc_s);
      2:       return 32'(pc_b);
      default: return 32'(pc_m);
    endcase
  endfunction

  function automatic logic [31:0] obs_r1(input int id);
    case (id)
      0:       return 32'(r1_a);
      1:       return 32'(r1_s);
      2:       return 32'(r1_b);
      default: return 32'(r1_m);
    endcase
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_pc"}, obs_pc(e.id), e.pc);
      chk({e.tag, "_r1"}, obs_r1(e.id), e.r1);
    end
  endtask

  // Reference behaviour of the default program at one clock edge.
  task automatic cyc_a(input logic rst, input logic s, input string tag);
    logic eff;
    exp_t e;
    rst_a = rst;
    sw    = s;
    if (rst) begin
      m_pc = 8'd0;
      m_r1 = 8'd0;
      m_s1 = 1'b0;
      m_s2 = 1'b0;
    end else begin
      eff = SYNC ? m_s2 : s;
      case (m_pc)
        8'd0: begin m_r1 = 8'd0; m_pc = 8'd1; end
        8'd1: m_pc = eff ? 8'd4 : 8'd2;
        8'd2: begin m_r1 = m_r1 - 8'd1; m_pc = 8'd3; end
        8'd4: begin m_r1 = m_r1 + 8'd1; m_pc = 8'd5; end
        default: m_pc = 8'd1;
      endcase
      m_s2 = m_s1;
      m_s1 = s;
    end
    e.id  = 0;
    e.pc  = 32'(m_pc);
    e.r1  = 32'(m_r1);
    e.tag = tag;
    sb.push_back(e);
    tick();
  endtask

  task automatic push(input int id, input int p, input int r,
                      input string tag);
    exp_t e;
    e.id  = id;
    e.pc  = 32'(p);
    e.r1  = 32'(r);
    e.tag = tag;
    sb.push_back(e);
  endtask

  int sub_pc[12]  = '{1, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
  int sub_r1[12]  = '{0, 3, 'hFE, 'hFE, 'hFE, 'hFE,
                      'hFE, 'hFE, 'hFE, 'hFE, 'hFE, 'hFE};
  int bnz_pc[12]  = '{1, 2, 1, 2, 3, 3, 3, 3, 3, 3, 3, 3};
  int bnz_r1[12]  = '{2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int misc_pc[12] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4};
  int misc_r1[12] = '{0, 7, 'hE, 'hE, 'hE, 1, 1, 1, 1, 7, 'hE, 'hE};

  initial begin
    int n;
    rst_a = 1'b1;
    rst_p = 1'b1;
    sw    = 1'b1;

    cyc_a(1'b1, 1'b1, "rst");
    cyc_a(1'b1, 1'b1, "rst");
    for (int i = 0; i < 30; i++) cyc_a(1'b0, 1'b1, "up");
    for (int i = 0; i < 45; i++) cyc_a(1'b0, 1'b0, "down");

    n = 0;
    while ((m_r1 != 8'h07) && (n < 300)) begin
      cyc_a(1'b0, 1'b1, "up2");
      n++;
    end
    chk("r1_seven", 32'(r1_a), 32'h07);
    cyc_a(1'b1, 1'b1, "midrst");
    for (int i = 0; i < 12; i++) cyc_a(1'b0, 1'b1, "restart");

    chk("sub_rst_pc", 32'(pc_s), 32'd0);
    chk("misc_rst_r1", 32'(r1_m), 32'd0);
    rst_p = 1'b0;
    for (int k = 0; k < 12; k++) begin
      push(1, sub_pc[k],  sub_r1[k],  "sub");
      push(2, bnz_pc[k],  bnz_r1[k],  "bnz");
      push(3, misc_pc[k], misc_r1[k], "misc");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/puc_cpu.md
PUC_CPU -- requirements
Module: puc_cpu

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, program-counter width and ROM depth 2^PC_WIDTH; legal range 2..8.
REQ-002 SHALL have parameter REGISTER_WIDTH, default 8, width of each general register; legal range 8..32.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port isReset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port switch, input, 1, external switch level sampled by branch instruction.
REQ-006 SHALL have port pc, output, PC_WIDTH, current program counter (registered).
REQ-007 SHALL have port register1Value, output, REGISTER_WIDTH, direct view of register r1 (registered, no added logic).

Function
REQ-008 SHALL execute one 16-bit instruction per clock from an internal ROM addressed by pc; fields: opcode[15:12], rd[11:10], rs[9:8], imm[7:0].
REQ-009 SHALL hold four registers r0..r3; r0 is writable and not hardwired to zero.
REQ-010 SHALL implement opcodes: 0 NOP; 1 LDI rd<=imm; 2 ADD rd<=rd+rs; 3 SUB rd<=rd-rs; 4 ADDI rd<=rd+imm; 5 MOV rd<=rs; 6 JMP pc<=imm; 7 BSW pc<=imm if switch==1; 8 BNZ pc<=imm if rd!=0; 9 HALT pc holds; 10-15 behave as NOP.
REQ-011 SHALL zero-extend imm to REGISTER_WIDTH; all arithmetic wraps modulo 2^REGISTER_WIDTH, no flags.
REQ-012 SHALL truncate branch/jump targets to PC_WIDTH bits.
REQ-013 SHALL advance pc by 1 for non-taken/non-control instructions, wrapping from 2^PC_WIDTH-1 to 0.
REQ-014 SHALL make register writes visible on register1Value the cycle after the executing edge; no pipeline, no hazards.
REQ-015 SHALL, once HALT executes, keep pc and registers frozen until reset.
REQ-016 SHALL initialise ROM with default program: 0 LDI r1,0; 1 BSW 4; 2 ADDI r1,0xFF; 3 JMP 1; 4 ADDI r1,1; 5 JMP 1; all other words NOP.
REQ-017 SHALL, with the default program, increment r1 by 1 per 3-cycle loop while switch=1 and decrement by 1 while switch=0.

Reset
REQ-018 SHALL, on any rising edge with isReset=1, set pc=0 and r0..r3=0, overriding the instruction in flight.
REQ-019 SHALL resume execution from address 0 on the first edge after isReset deasserts; reset mid-loop discards partial progress.
REQ-020 SHALL leave ROM contents unaffected by reset.

Configuration
REQ-021 SHALL provide macro PUC_CPU_SWITCH_SYNC_EN: when defined, switch passes through a 2-flop synchroniser (reset to 0) before BSW sees it, adding 2 cycles of latency; when undefined, BSW uses switch directly in the executing cycle.

Structure
REQ-022 SHALL place opcode enumeration, field-position constants and instruction-word width (16) in package puc_cpu_pkg.
REQ-023 SHALL implement the 4-entry register file as sub-module puc_cpu_regfile (one write port, two combinational read ports, r1 tap output).
REQ-024 SHALL keep ROM, decode, ALU and pc logic inside puc_cpu.

Verification
REQ-025 Reset held 2 cycles, switch=1, release -> pc sequence 0,1,4,5,1,4,5...; register1Value 0 then 1,2,3 each 3 cycles apart.
REQ-026 Run 30 cycles switch=1, set switch=0 -> register1Value decrements by 1 per 3 cycles, 0x00 wraps to 0xFF.
REQ-027 Assert isReset mid-loop with register1Value=0x07 -> next edge pc=0, register1Value=0; counting restarts from 0.
REQ-028 Load ROM with LDI r2,5; LDI r1,3; SUB r1,r2; HALT -> register1Value=0xFE, pc stays 3 indefinitely.
REQ-029 Load ROM with LDI r1,2; ADDI r1,0xFF; BNZ r1,1; HALT -> register1Value 2,1,0 then pc=3 held.
REQ-030 With PUC_CPU_SWITCH_SYNC_EN defined, toggle switch 1->0 -> first decrement occurs 2 cycles later than without the macro.
